series_ctrl: RTL

//   FSM sequencer for the iterative series datapath (x/num/sum/overflow pipeline register).

---
 rtl/series_pkg.sv | 31 +++
 rtl/series_wait_cnt.sv | 37 +++
 rtl/series_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/series_pkg.sv
// Shared types and helpers for the series sequencer and its multicycle helpers.
package series_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_ACC   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam int STATE_W = 3;

  typedef struct packed {
    logic load;
    logic en;
  } dp_ctrl_t;

  localparam int DP_CTRL_W = $bits(dp_ctrl_t);

  // Smallest width w with 2**w >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/series_wait_cnt.sv
// Latency down-counter: load arms it with LAT-1, expire is high once it reaches zero.
module series_wait_cnt
  import series_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (LAT > 1) ? clog2(LAT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LAT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/series_ctrl.sv
// Sequencer for the iterative series datapath: load, wait out term latency,
// capture one term per pass, finish after N_TERMS terms or on overflow.
module series_ctrl
  import series_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             overflow_in,
  output logic             dp_load,
  output logic             dp_en,
  output logic             dp_clr,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  if (CNT_W < clog2(N_TERMS + 1)) begin : g_bad_cnt_w
    $error("series_ctrl: CNT_W too narrow to hold N_TERMS");
  end
  if (N_TERMS < 1) begin : g_bad_n_terms
    $error("series_ctrl: N_TERMS must be at least 1");
  end
  if (MUL_LAT < 1) begin : g_bad_mul_lat
    $error("series_ctrl: MUL_LAT must be at least 1");
  end

  localparam logic [CNT_W-1:0] TERM_MAX = CNT_W'(N_TERMS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] term_q, term_d;
  dp_ctrl_t         dp_q, dp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             wait_load, wait_en, wait_expire;

  series_wait_cnt #(
    .LAT(MUL_LAT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (wait_load),
    .en    (wait_en),
    .expire(wait_expire)
  );

  always_comb begin
    state_d   = state_q;
    term_d    = term_q;
    wait_load = 1'b0;
    wait_en   = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) state_d = S_LOAD;
        end
        S_LOAD: begin
          term_d    = '0;
          wait_load = 1'b1;
          state_d   = S_CALC;
        end
        S_CALC: begin
          wait_en = 1'b1;
          if (wait_expire) state_d = S_ACC;
        end
        S_ACC: begin
          if (term_q != TERM_MAX) term_d = term_q + 1'b1;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          // Overflow outranks completion so a bad last term still reports error.
          if (overflow_in) begin
            state_d = S_ERR;
          end else if (term_q == TERM_MAX) begin
            state_d = S_DONE;
          end else begin
            wait_load = 1'b1;
            state_d   = S_CALC;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    dp_d.load = (state_d == S_LOAD);
    dp_d.en   = (state_d == S_LOAD) || (state_d == S_ACC);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      term_q  <= '0;
      dp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign dp_load  = dp_q.load;
  assign dp_en    = dp_q.en;
  assign dp_clr   = abort && busy_q;
  assign term_idx = term_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
